// File: rtl/wb_stage_pkg.sv
// Shared constants and bus payload types for the write-back stage and its CP0 block.
package wb_stage_pkg;

  localparam int unsigned MS_TO_WS_BUS_WD = 73;
  localparam int unsigned MS_EX_BUS_WD    = 10;
  localparam int unsigned WS_TO_DS_BUS_WD = 36;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [4:0]  EXC_SYS  = 5'h08;
  localparam logic [31:0] EX_ENTRY = 32'hbfc0_0380;

  typedef struct packed {
    logic [3:0]  reg_we;
    logic [4:0]  dest;
    logic [31:0] result;
    logic [31:0] pc;
  } ms_to_ws_t;

  typedef struct packed {
    logic       bd;
    logic       sys;
    logic       mfc0;
    logic       mtc0;
    logic       eret;
    logic [4:0] cp0_addr;
  } ms_ex_t;

endpackage

// File: rtl/wb_stage_cp0.sv
// CP0 subset (Count, Compare, Status, Cause, EPC) with timer, syscall/eret updates and interrupt request.
module cp0_regs
  import wb_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en_i,
  input  logic [4:0]  addr_i,
  input  logic [31:0] wdata_i,
  input  logic        sys_i,
  input  logic        eret_i,
  input  logic        bd_i,
  input  logic [31:0] pc_i,
  output logic [31:0] rdata_o,
  output logic [31:0] epc_o,
  output logic        int_req_o
);

  logic        tick_q,    tick_d;
  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [7:0]  im_q,      im_d;
  logic        exl_q,     exl_d;
  logic        ie_q,      ie_d;
  logic        bd_q,      bd_d;
  logic        ti_q,      ti_d;
  logic [1:0]  ip_sw_q,   ip_sw_d;
  logic [4:0]  exccode_q, exccode_d;
  logic [31:0] epc_q,     epc_d;

  logic [31:0] status_w;
  logic [31:0] cause_w;
  logic [7:0]  ip_w;

  // BEV is hardwired to 1; IP[15] mirrors the timer interrupt.
  assign status_w = {9'b0, 1'b1, 6'b0, im_q, 6'b0, exl_q, ie_q};
  assign ip_w     = {ti_q, 5'b0, ip_sw_q};
  assign cause_w  = {bd_q, ti_q, 14'b0, ip_w, 1'b0, exccode_q, 2'b0};

  always_comb begin
    tick_d    = ~tick_q;
    count_d   = count_q + 32'(tick_q);
    compare_d = compare_q;
    im_d      = im_q;
    exl_d     = exl_q;
    ie_d      = ie_q;
    bd_d      = bd_q;
    ti_d      = ti_q;
    ip_sw_d   = ip_sw_q;
    exccode_d = exccode_q;
    epc_d     = epc_q;

    if (count_q == compare_q) ti_d = 1'b1;

    if (wr_en_i) begin
      case (addr_i)
        CP0_COUNT:   count_d = wdata_i;
        CP0_COMPARE: begin
          compare_d = wdata_i;
          ti_d      = 1'b0;
        end
        CP0_STATUS: begin
          im_d  = wdata_i[15:8];
          exl_d = wdata_i[1];
          ie_d  = wdata_i[0];
        end
        CP0_CAUSE:   ip_sw_d = wdata_i[9:8];
        CP0_EPC:     epc_d   = wdata_i;
        default:     ;
      endcase
    end

    // A nested exception keeps the original return address and BD flag.
    if (sys_i) begin
      exccode_d = EXC_SYS;
      exl_d     = 1'b1;
      if (!exl_q) begin
        bd_d  = bd_i;
        epc_d = bd_i ? pc_i - 32'd4 : pc_i;
      end
    end

    if (eret_i) exl_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q    <= 1'b0;
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      im_q      <= 8'd0;
      exl_q     <= 1'b0;
      ie_q      <= 1'b0;
      bd_q      <= 1'b0;
      ti_q      <= 1'b0;
      ip_sw_q   <= 2'd0;
      exccode_q <= 5'd0;
      epc_q     <= 32'd0;
    end else begin
      tick_q    <= tick_d;
      count_q   <= count_d;
      compare_q <= compare_d;
      im_q      <= im_d;
      exl_q     <= exl_d;
      ie_q      <= ie_d;
      bd_q      <= bd_d;
      ti_q      <= ti_d;
      ip_sw_q   <= ip_sw_d;
      exccode_q <= exccode_d;
      epc_q     <= epc_d;
    end
  end

  always_comb begin
    rdata_o = 32'd0;
    case (addr_i)
      CP0_COUNT:   rdata_o = count_q;
      CP0_COMPARE: rdata_o = compare_q;
      CP0_STATUS:  rdata_o = status_w;
      CP0_CAUSE:   rdata_o = cause_w;
      CP0_EPC:     rdata_o = epc_q;
      default:     rdata_o = 32'd0;
    endcase
  end

  assign epc_o     = epc_q;
  assign int_req_o = ie_q & ~exl_q & (|(ip_w & im_q));

endmodule

// File: rtl/wb_stage.sv
// Write-back stage: registers the memory-stage result, drives GPR writes/forwarding/trace, resolves syscall and eret.
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ms_to_ws_valid,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  input  logic [MS_EX_BUS_WD-1:0]    ms_ex_bus,
  output logic                       ws_allowin,
  output logic [3:0]                 rf_we,
  output logic [4:0]                 rf_waddr,
  output logic [31:0]                rf_wdata,
  output logic                       ws_write_reg,
  output logic [4:0]                 ws_reg_dest,
  output logic [WS_TO_DS_BUS_WD-1:0] ws_to_ds_bus,
  output logic                       flush,
  output logic [31:0]                flush_pc,
  output logic                       int_req,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_wen,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  logic      ws_valid_q, ws_valid_d;
  ms_to_ws_t bus_q,      bus_d;
  ms_ex_t    ex_q,       ex_d;
  ms_to_ws_t bus_in;
  ms_ex_t    ex_in;

  logic        ws_ex;
  logic [31:0] cp0_rdata;
  logic [31:0] cp0_epc;

  assign bus_in = ms_to_ws_bus;
  assign ex_in  = ms_ex_bus;

  // The stage always completes in one cycle; an arriving instruction is squashed while flush is high.
  always_comb begin
    ws_valid_d = flush ? 1'b0 : ms_to_ws_valid;
    bus_d      = ms_to_ws_valid ? bus_in : bus_q;
    ex_d       = ms_to_ws_valid ? ex_in  : ex_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ws_valid_q <= 1'b0;
      bus_q      <= '0;
      ex_q       <= '0;
    end else begin
      ws_valid_q <= ws_valid_d;
      bus_q      <= bus_d;
      ex_q       <= ex_d;
    end
  end

  cp0_regs u_cp0 (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (ws_valid_q & ex_q.mtc0),
    .addr_i    (ex_q.cp0_addr),
    .wdata_i   (bus_q.result),
    .sys_i     (ws_valid_q & ex_q.sys),
    .eret_i    (ws_valid_q & ex_q.eret),
    .bd_i      (ex_q.bd),
    .pc_i      (bus_q.pc),
    .rdata_o   (cp0_rdata),
    .epc_o     (cp0_epc),
    .int_req_o (int_req)
  );

  assign ws_ex    = ws_valid_q & (ex_q.sys | ex_q.eret);
  assign flush    = ws_ex;
  assign flush_pc = (ws_valid_q & ex_q.eret) ? cp0_epc : EX_ENTRY;

  assign ws_allowin   = 1'b1;
  assign rf_we        = bus_q.reg_we & {4{ws_valid_q & ~ws_ex}};
  assign rf_waddr     = bus_q.dest;
  assign rf_wdata     = ex_q.mfc0 ? cp0_rdata : bus_q.result;
  assign ws_write_reg = ws_valid_q & (|bus_q.reg_we);
  assign ws_reg_dest  = bus_q.dest;
  assign ws_to_ds_bus = {rf_wdata, rf_we};

  assign debug_wb_pc       = bus_q.pc;
  assign debug_wb_rf_wen   = rf_we;
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: word-level CP0/pipeline model, per-cycle compare, directed and random stimulus.
module tb_wb_stage;

  logic        clk;
  logic        reset;
  logic        ms_to_ws_valid;
  logic [72:0] ms_to_ws_bus;
  logic [9:0]  ms_ex_bus;
  logic        ws_allowin;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ws_write_reg;
  logic [4:0]  ws_reg_dest;
  logic [35:0] ws_to_ds_bus;
  logic        flush;
  logic [31:0] flush_pc;
  logic        int_req;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  wb_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .ms_ex_bus         (ms_ex_bus),
    .ws_allowin        (ws_allowin),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .ws_write_reg      (ws_write_reg),
    .ws_reg_dest       (ws_reg_dest),
    .ws_to_ds_bus      (ws_to_ds_bus),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .int_req           (int_req),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Reference state: the instruction sitting in WB plus the CP0 registers as whole words.
  bit          m_valid;
  logic [72:0] m_bus;
  logic [9:0]  m_ex;
  logic [31:0] m_count, m_compare, m_status, m_cause, m_epc;
  bit          m_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [72:0] mk_bus(input logic [3:0] we, input logic [4:0] dest,
                                         input logic [31:0] res, input logic [31:0] pc);
    return {we, dest, res, pc};
  endfunction

  function automatic logic [9:0] mk_ex(input logic bd, input logic sys, input logic mfc0,
                                       input logic mtc0, input logic eret, input logic [4:0] a);
    return {bd, sys, mfc0, mtc0, eret, a};
  endfunction

  function automatic logic [31:0] m_cp0_read(input logic [4:0] a);
    case (a)
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause | (32'(m_cause[30]) << 15);
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_bus = '0; m_ex = '0;
    m_count = 0; m_compare = 0; m_status = 32'h0040_0000; m_cause = 0; m_epc = 0;
    m_tick = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [72:0] bus, input logic [9:0] ex);
    logic        wr, s, er;
    logic [4:0]  a;
    logic [31:0] res, pc, n_count, n_compare, n_status, n_cause, n_epc;
    wr  = m_valid && m_ex[6];
    s   = m_valid && m_ex[8];
    er  = m_valid && m_ex[5];
    a   = m_ex[4:0];
    res = m_bus[63:32];
    pc  = m_bus[31:0];
    n_count   = m_count + (m_tick ? 32'd1 : 32'd0);
    n_compare = m_compare;
    n_status  = m_status;
    n_cause   = m_cause;
    n_epc     = m_epc;
    if (wr && a == 5'd9)  n_count   = res;
    if (wr && a == 5'd11) n_compare = res;
    if (wr && a == 5'd12) n_status  = (m_status & ~32'h0000_ff03) | (res & 32'h0000_ff03);
    if (wr && a == 5'd13) n_cause[9:8] = res[9:8];
    if (wr && a == 5'd14) n_epc     = res;
    if (wr && a == 5'd11) n_cause[30] = 1'b0;
    else if (m_count == m_compare) n_cause[30] = 1'b1;
    if (s) begin
      n_cause[6:2] = 5'h08;
      n_status[1]  = 1'b1;
      if (!m_status[1]) begin
        n_cause[31] = m_ex[9];
        n_epc       = m_ex[9] ? pc - 32'd4 : pc;
      end
    end
    if (er) n_status[1] = 1'b0;
    m_count = n_count; m_compare = n_compare; m_status = n_status; m_cause = n_cause; m_epc = n_epc;
    m_tick  = !m_tick;
    m_valid = (s || er) ? 1'b0 : v;
    if (v) begin
      m_bus = bus;
      m_ex  = ex;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  logic [3:0]  e_we;
  logic [31:0] e_wdata;
  logic        e_ex, e_int;
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_ex    = m_valid && (m_ex[8] || m_ex[5]);
        e_we    = (m_valid && !e_ex) ? m_bus[72:69] : 4'd0;
        e_wdata = m_ex[7] ? m_cp0_read(m_ex[4:0]) : m_bus[63:32];
        e_int   = m_status[0] && !m_status[1] &&
                  ((({m_cause[30], 5'b0, m_cause[9:8]}) & m_status[15:8]) != 8'd0);
        chk("allowin",   32'(ws_allowin), 32'd1);
        chk("rf_we",     32'(rf_we), 32'(e_we));
        chk("rf_waddr",  32'(rf_waddr), 32'(m_bus[68:64]));
        chk("rf_wdata",  rf_wdata, e_wdata);
        chk("write_reg", 32'(ws_write_reg), 32'(m_valid && (m_bus[72:69] != 4'd0)));
        chk("reg_dest",  32'(ws_reg_dest), 32'(m_bus[68:64]));
        chk("fwd_data",  ws_to_ds_bus[35:4], e_wdata);
        chk("fwd_we",    32'(ws_to_ds_bus[3:0]), 32'(e_we));
        chk("flush",     32'(flush), 32'(e_ex));
        if (e_ex) chk("flush_pc", flush_pc, m_ex[5] ? m_epc : 32'hbfc0_0380);
        chk("int_req",   32'(int_req), 32'(e_int));
        chk("dbg_pc",    debug_wb_pc, m_bus[31:0]);
        chk("dbg_wen",   32'(debug_wb_rf_wen), 32'(e_we));
        chk("dbg_wnum",  32'(debug_wb_rf_wnum), 32'(m_bus[68:64]));
        chk("dbg_wdata", debug_wb_rf_wdata, e_wdata);
      end
    end
  end

  task automatic cycle(input logic v, input logic [72:0] bus, input logic [9:0] ex);
    ms_to_ws_valid = v;
    ms_to_ws_bus   = bus;
    ms_ex_bus      = ex;
    @(posedge clk);
    model_step(v, bus, ex);
    @(negedge clk);
  endtask

  task automatic mfc0(input logic [4:0] a);
    cycle(1'b1, mk_bus(4'hf, 5'd4, 32'h0, 32'hbfc0_0500), mk_ex(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, a));
    #1;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] val);
    cycle(1'b1, mk_bus(4'h0, 5'd0, val, 32'hbfc0_0600), mk_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a));
  endtask

  task automatic rand_cycle();
    logic [4:0]  a;
    logic [31:0] val;
    logic [3:0]  we;
    int unsigned op;
    logic [4:0]  addrs [6];
    addrs = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
    op  = $urandom_range(0, 9);
    a   = addrs[$urandom_range(0, 5)];
    val = (a == 5'd9 || a == 5'd11) ? 32'($urandom_range(0, 15)) : $urandom;
    we  = 4'($urandom);
    if (op <= 3)
      cycle($urandom_range(0, 4) != 0, mk_bus(we, 5'($urandom), $urandom, {$urandom, 2'b00} >> 2 << 2),
            mk_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'($urandom)));
    else if (op <= 5)
      cycle(1'b1, mk_bus(we, 5'($urandom), $urandom, $urandom & 32'hffff_fffc),
            mk_ex(1'($urandom), 1'b0, 1'b1, 1'b0, 1'b0, ($urandom_range(0, 3) == 0) ? 5'($urandom) : a));
    else if (op <= 7)
      cycle(1'b1, mk_bus(4'h0, 5'd0, val, $urandom & 32'hffff_fffc), mk_ex(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, a));
    else
      cycle(1'b1, mk_bus(we, 5'($urandom), $urandom, $urandom & 32'hffff_fffc),
            mk_ex(1'($urandom), op == 8, 1'b0, 1'b0, op == 9, 5'($urandom)));
  endtask

  initial begin
    reset = 1'b1;
    ms_to_ws_valid = 1'b0;
    ms_to_ws_bus   = '0;
    ms_ex_bus      = '0;
    model_reset();
    @(negedge clk);
    chk("rst_rf_we",    32'(rf_we), 32'd0);
    chk("rst_wdata",    rf_wdata, 32'd0);
    chk("rst_flush",    32'(flush), 32'd0);
    chk("rst_flush_pc", flush_pc, 32'hbfc0_0380);
    chk("rst_int",      32'(int_req), 32'd0);
    chk("rst_dbg_pc",   debug_wb_pc, 32'd0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Plain write-back with partial byte enables.
    cycle(1'b1, mk_bus(4'b0110, 5'd5, 32'h1234_5678, 32'hbfc0_0010), '0);
    #1;
    chk("wb_we",    32'(rf_we), 32'h6);
    chk("wb_waddr", 32'(rf_waddr), 32'd5);
    chk("wb_wdata", rf_wdata, 32'h1234_5678);
    chk("wb_pc",    debug_wb_pc, 32'hbfc0_0010);

    // Syscall outside a delay slot; the instruction behind it is squashed.
    cycle(1'b1, mk_bus(4'hf, 5'd3, 32'h0, 32'hbfc0_0100), mk_ex(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0));
    #1;
    chk("sys_flush",    32'(flush), 32'd1);
    chk("sys_flush_pc", flush_pc, 32'hbfc0_0380);
    chk("sys_rf_we",    32'(rf_we), 32'd0);
    cycle(1'b1, mk_bus(4'hf, 5'd9, 32'h55, 32'hbfc0_0104), '0);
    #1;
    chk("drop_write_reg", 32'(ws_write_reg), 32'd0);
    chk("drop_rf_we",     32'(rf_we), 32'd0);
    mfc0(5'd14); chk("sys_epc", rf_wdata, 32'hbfc0_0100);
    mfc0(5'd12); chk("sys_exl", 32'(rf_wdata[1]), 32'd1);
    mfc0(5'd13); chk("sys_exccode", 32'(rf_wdata[6:2]), 32'd8);

    // Eret returns to a programmed EPC.
    mtc0(5'd14, 32'hbfc0_0200);
    cycle(1'b1, mk_bus(4'h0, 5'd0, 32'h0, 32'hbfc0_0300), mk_ex(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0));
    #1;
    chk("eret_flush",    32'(flush), 32'd1);
    chk("eret_flush_pc", flush_pc, 32'hbfc0_0200);
    cycle(1'b0, '0, '0);
    mfc0(5'd12); chk("eret_exl", 32'(rf_wdata[1]), 32'd0);

    // Syscall in a delay slot.
    cycle(1'b1, mk_bus(4'hf, 5'd3, 32'h0, 32'hbfc0_0100), mk_ex(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0));
    cycle(1'b0, '0, '0);
    mfc0(5'd14); chk("bd_epc", rf_wdata, 32'hbfc0_00fc);
    mfc0(5'd13); chk("bd_cause_bd", 32'(rf_wdata[31]), 32'd1);

    // Timer interrupt through IM[7].
    mtc0(5'd11, 32'd4);
    mtc0(5'd9,  32'd0);
    mtc0(5'd12, 32'h0040_8001);
    for (int i = 0; i < 40 && !int_req; i++) cycle(1'b0, '0, '0);
    #1;
    chk("timer_int", 32'(int_req), 32'd1);
    mfc0(5'd13);
    chk("timer_ti",   32'(rf_wdata[30]), 32'd1);
    chk("timer_ip15", 32'(rf_wdata[15]), 32'd1);
    mtc0(5'd11, 32'd100);
    cycle(1'b0, '0, '0);
    #1;
    chk("timer_int_clr", 32'(int_req), 32'd0);
    mfc0(5'd13); chk("timer_ti_clr", 32'(rf_wdata[30]), 32'd0);

    for (int i = 0; i < 500; i++) rand_cycle();

    // Asynchronous reset in the middle of a write.
    cycle(1'b0, '0, '0);
    cycle(1'b1, mk_bus(4'hf, 5'd7, 32'hdead_beef, 32'h0000_0100), '0);
    #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    #1;
    chk("arst_rf_we",     32'(rf_we), 32'd0);
    chk("arst_write_reg", 32'(ws_write_reg), 32'd0);
    chk("arst_wdata",     rf_wdata, 32'd0);
    chk("arst_flush",     32'(flush), 32'd0);
    chk("arst_flush_pc",  flush_pc, 32'hbfc0_0380);
    chk("arst_int",       32'(int_req), 32'd0);
    chk("arst_dbg_pc",    debug_wb_pc, 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 100; i++) rand_cycle();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
